snake_body_update: RTL

//  Consumer of the frame-rate update trigger. On each trigger pulse it advances
//  the snake one grid cell in the latched direction and shifts the body segments.
//  It then runs a sequential self-collision scan and applies growth requests.

---
 rtl/snake_body_update.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/snake_body_update.sv
// Snake body register file: one-cell move per update trigger, sequential self-collision scan, growth.
// Optional define WALL_KILL_EN: leaving the grid ends the game instead of wrapping around.
module snake_body_update #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int COORD_BIT = 5,
    parameter int MAX_LEN   = 16,
    parameter int LEN_BIT   = 5,
    parameter int INIT_LEN  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    // dir_valid and grow have no ready: they are taken on any cycle outside DEAD.
    // update_trigger is taken only while busy is low; a trigger seen while busy is dropped.
    input  logic                 update_trigger,
    input  logic [1:0]           dir_in,
    input  logic                 dir_valid,
    input  logic                 grow,
    output logic [COORD_BIT-1:0] head_x,
    output logic [COORD_BIT-1:0] head_y,
    input  logic [LEN_BIT-1:0]   seg_idx,
    output logic [COORD_BIT-1:0] seg_x,
    output logic [COORD_BIT-1:0] seg_y,
    output logic                 seg_live,
    output logic [LEN_BIT-1:0]   length,
    output logic                 busy,
    output logic                 game_over,
    output logic [1:0]           state_dbg
);
    localparam int IDX_BIT = $clog2(MAX_LEN);
    localparam logic [COORD_BIT-1:0] X_MAX = COORD_BIT'(GRID_W - 1);
    localparam logic [COORD_BIT-1:0] Y_MAX = COORD_BIT'(GRID_H - 1);
    localparam logic [COORD_BIT-1:0] X_MID = COORD_BIT'(GRID_W / 2);
    localparam logic [COORD_BIT-1:0] Y_MID = COORD_BIT'(GRID_H / 2);
    localparam logic [LEN_BIT-1:0]   LEN_MAX = LEN_BIT'(MAX_LEN);
    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_D = 2'd1;
    localparam logic [1:0] DIR_L = 2'd2;

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, DEAD} state_t;

    state_t               state_q, state_d;
    logic [1:0]           dir_q, dir_d;
    logic [1:0]           pend_q, pend_d;
    logic                 grow_pend_q, grow_pend_d;
    logic [LEN_BIT-1:0]   len_q, len_d;
    logic [IDX_BIT-1:0]   k_q, k_d;
    logic [COORD_BIT-1:0] body_x_q [MAX_LEN];
    logic [COORD_BIT-1:0] body_x_d [MAX_LEN];
    logic [COORD_BIT-1:0] body_y_q [MAX_LEN];
    logic [COORD_BIT-1:0] body_y_d [MAX_LEN];
    logic [COORD_BIT-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic                 rd_live_q, rd_live_d;
    logic [COORD_BIT-1:0] next_x, next_y;
    logic                 off_grid, wall_hit;

    // Wrap is modulo the grid size, so edges are detected explicitly rather than by overflow.
    always_comb begin
        next_x   = body_x_q[0];
        next_y   = body_y_q[0];
        off_grid = 1'b0;
        case (pend_q)
            DIR_R: if (body_x_q[0] == X_MAX) begin next_x = '0; off_grid = 1'b1; end
                   else next_x = body_x_q[0] + 1'b1;
            DIR_D: if (body_y_q[0] == Y_MAX) begin next_y = '0; off_grid = 1'b1; end
                   else next_y = body_y_q[0] + 1'b1;
            DIR_L: if (body_x_q[0] == '0) begin next_x = X_MAX; off_grid = 1'b1; end
                   else next_x = body_x_q[0] - 1'b1;
            default: if (body_y_q[0] == '0) begin next_y = Y_MAX; off_grid = 1'b1; end
                     else next_y = body_y_q[0] - 1'b1;
        endcase
    end

`ifdef WALL_KILL_EN
    assign wall_hit = off_grid;
`else
    assign wall_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        grow_pend_d = grow_pend_q;
        len_d       = len_q;
        k_d         = k_q;
        body_x_d    = body_x_q;
        body_y_d    = body_y_q;

        // Reversal is judged against the direction actually used, not the pending one.
        if (state_q != DEAD) begin
            if (dir_valid && (dir_in != (dir_q ^ 2'd2))) pend_d = dir_in;
            if (grow) grow_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: if (update_trigger) state_d = MOVE;
            MOVE: begin
                if (wall_hit) begin
                    state_d = DEAD;
                end else begin
                    dir_d = pend_q;
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        body_x_d[i] = body_x_q[i-1];
                        body_y_d[i] = body_y_q[i-1];
                    end
                    body_x_d[0] = next_x;
                    body_y_d[0] = next_y;
                    if ((grow_pend_q || grow) && (len_q < LEN_MAX)) len_d = len_q + 1'b1;
                    grow_pend_d = 1'b0;
                    k_d         = IDX_BIT'(1);
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if ((body_x_q[0] == body_x_q[k_q]) && (body_y_q[0] == body_y_q[k_q])) state_d = DEAD;
                else if (LEN_BIT'(k_q) == len_q - 1'b1) state_d = IDLE;
                else k_d = k_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_x_d    = '0;
        rd_y_d    = '0;
        rd_live_d = seg_idx < len_q;
        if (seg_idx < LEN_MAX) begin
            rd_x_d = body_x_q[seg_idx[IDX_BIT-1:0]];
            rd_y_d = body_y_q[seg_idx[IDX_BIT-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= DIR_R;
            pend_q      <= DIR_R;
            grow_pend_q <= 1'b0;
            len_q       <= LEN_BIT'(INIT_LEN);
            k_q         <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x_q[i] <= (i < INIT_LEN) ? X_MID - COORD_BIT'(i) : '0;
                body_y_q[i] <= (i < INIT_LEN) ? Y_MID : '0;
            end
            rd_x_q    <= '0;
            rd_y_q    <= '0;
            rd_live_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            grow_pend_q <= grow_pend_d;
            len_q       <= len_d;
            k_q         <= k_d;
            body_x_q    <= body_x_d;
            body_y_q    <= body_y_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            rd_live_q   <= rd_live_d;
        end
    end

    assign head_x    = body_x_q[0];
    assign head_y    = body_y_q[0];
    assign seg_x     = rd_x_q;
    assign seg_y     = rd_y_q;
    assign seg_live  = rd_live_q;
    assign length    = len_q;
    assign busy      = (state_q == MOVE) || (state_q == CHECK);
    assign game_over = (state_q == DEAD);
    assign state_dbg = state_q;
endmodule
